// File: rtl/frame_stream_gen.sv
// Replays a stored frame from synchronous pixel memory as a vsync/href/clken pixel stream.
// Latency: post_* outputs and frame_done trail the internal timing/rd_en by 2 cycles.
// Backpressure: none; start is ignored unless idle, continuous chains frames back to back.
module frame_stream_gen #(
    parameter int IMG_W       = 32,
    parameter int IMG_H       = 32,
    parameter int H_BLANK     = 8,
    parameter int VSYNC_LINES = 2,
    parameter int V_BACK      = 2,
    parameter int V_FRONT     = 2,
    parameter int ADDR_W      = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              continuous,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [23:0]       rd_data,
    output logic              post_frame_vsync,
    output logic              post_frame_href,
    output logic              post_frame_clken,
    output logic [23:0]       post_img_Bit,
    output logic              busy,
    output logic              frame_done
);
    localparam logic [15:0] LINE_LAST = 16'(IMG_W + H_BLANK - 1);
    localparam logic [15:0] ACT_W     = 16'(IMG_W);

    typedef enum logic [2:0] {IDLE, VSYNC, VBACK, ACTIVE, VFRONT} state_t;

    state_t      state;
    logic [15:0] h_cnt;
    logic [15:0] v_cnt;
    logic [15:0] h_nxt;
    logic [15:0] state_lines;
    logic        line_end;
    logic        state_end;
    logic        frame_end;
    logic        frame_start;
    logic        int_vsync;
    logic        vsync_d1;
    logic        href_d1;
    logic        done_d1;

    assign line_end    = (h_cnt == LINE_LAST);
    assign h_nxt       = line_end ? 16'd0 : h_cnt + 16'd1;
    assign state_end   = line_end && (v_cnt == state_lines - 16'd1);
    assign frame_end   = state_end && ((state == VFRONT) || ((state == ACTIVE) && (V_FRONT == 0)));
    assign frame_start = ((state == IDLE) && start) || (frame_end && continuous);

    always_comb begin
        state_lines = 16'd1;
        case (state)
            VSYNC:   state_lines = 16'(VSYNC_LINES);
            VBACK:   state_lines = 16'(V_BACK);
            ACTIVE:  state_lines = 16'(IMG_H);
            VFRONT:  state_lines = 16'(V_FRONT);
            default: state_lines = 16'd1;
        endcase
    end

    // int_vsync and rd_en are loaded with the decode of the position being entered,
    // so they always describe the current h_cnt/v_cnt position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            h_cnt     <= '0;
            v_cnt     <= '0;
            int_vsync <= 1'b0;
            rd_en     <= 1'b0;
        end else if (state == IDLE) begin
            h_cnt     <= '0;
            v_cnt     <= '0;
            int_vsync <= start;
            rd_en     <= 1'b0;
            if (start) state <= VSYNC;
        end else begin
            h_cnt <= h_nxt;
            if (!state_end) begin
                if (line_end) v_cnt <= v_cnt + 16'd1;
                int_vsync <= (state == VSYNC);
                rd_en     <= (state == ACTIVE) && (h_nxt < ACT_W);
            end else begin
                v_cnt     <= '0;
                int_vsync <= 1'b0;
                rd_en     <= 1'b0;
                case (state)
                    VSYNC: begin
                        state <= (V_BACK > 0) ? VBACK : ACTIVE;
                        rd_en <= (V_BACK == 0);
                    end
                    VBACK: begin
                        state <= ACTIVE;
                        rd_en <= 1'b1;
                    end
                    default: begin
                        if ((state == ACTIVE) && (V_FRONT > 0)) begin
                            state <= VFRONT;
                        end else if (continuous) begin
                            state     <= VSYNC;
                            int_vsync <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr <= '0;
        end else if (frame_start) begin
            rd_addr <= '0;
        end else if (rd_en) begin
            rd_addr <= rd_addr + ADDR_W'(1);
        end
    end

    // Two-stage alignment: stage 1 waits for memory data, stage 2 drives the stream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_d1         <= 1'b0;
            href_d1          <= 1'b0;
            done_d1          <= 1'b0;
            post_frame_vsync <= 1'b0;
            post_frame_href  <= 1'b0;
            post_frame_clken <= 1'b0;
            post_img_Bit     <= 24'd0;
            frame_done       <= 1'b0;
            busy             <= 1'b0;
        end else begin
            vsync_d1         <= int_vsync;
            href_d1          <= rd_en;
            done_d1          <= frame_end;
            post_frame_vsync <= vsync_d1;
            post_frame_href  <= href_d1;
            post_frame_clken <= href_d1;
            post_img_Bit     <= href_d1 ? rd_data : 24'd0;
            frame_done       <= done_d1;
            busy             <= (state != IDLE) || start || done_d1;
        end
    end
endmodule

// File: doc/frame_stream_gen.md
Name: frame_stream_gen

Overview:
- Transmitter for the pixel stream protocol (vsync / href / clken / 24-bit pixel) consumed by the image processing chain.
- Reads a stored frame from a synchronous pixel memory and replays it as a timed video stream with configurable blanking.
- Used as a bench/playback source and as the read-out stage after a frame buffer.

Parameters:
IMG_W, 32, active pixels per line
IMG_H, 32, active lines per frame
H_BLANK, 8, blank cycles appended after the active pixels of every line (>=1)
VSYNC_LINES, 2, lines with vsync high at frame start (>=1)
V_BACK, 2, blank lines after vsync, before the first active line (>=0)
V_FRONT, 2, blank lines after the last active line (>=0)
ADDR_W, 10, memory address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; starts a frame when idle
continuous  in  1  1 = start the next frame immediately after V_FRONT
rd_en  out  1  memory read strobe
rd_addr  out  ADDR_W  memory read address
rd_data  in  24  memory read data, valid the cycle after rd_en
post_frame_vsync  out  1  vsync of generated stream
post_frame_href  out  1  line-valid of generated stream
post_frame_clken  out  1  pixel clock enable (equal to href)
post_img_Bit  out  24  pixel data; 0 when href is low
busy  out  1  high from frame start through the end of V_FRONT
frame_done  out  1  one-cycle pulse on the last cycle of V_FRONT

Behaviour:
- Reset (async, immediate): every output is 0, the FSM goes to IDLE, and all counters clear. Reset mid-frame aborts the frame with no further rd_en.
- Line structure: each line is IMG_W+H_BLANK cycles, with h_cnt running 0..IMG_W+H_BLANK-1 and wrapping. v_cnt counts lines within the current state.
- FSM states: IDLE, VSYNC, VBACK, ACTIVE, VFRONT.
  - IDLE: start=1 goes to VSYNC next cycle with h_cnt=0. start in any other state is ignored.
  - VSYNC: lasts VSYNC_LINES lines. Internal vsync=1, href=0.
  - VBACK: lasts V_BACK lines; skipped when 0.
  - ACTIVE: lasts IMG_H lines. Internal href=1 for h_cnt<IMG_W.
  - VFRONT: lasts V_FRONT lines; skipped when 0. On its final cycle, frame_done=1 (a registered pulse aligned with the last post_* cycle of the frame). The FSM then goes to VSYNC if continuous=1, else IDLE. continuous is sampled only on that cycle.
  - If V_FRONT=0, frame_done fires on the last cycle of the final ACTIVE line, with the same transition.
- Memory read:
  - rd_en is registered and equals internal href.
  - rd_addr is 0 at frame start and increments after each rd_en, so it runs 0..IMG_W*IMG_H-1 in raster order. It does not advance during blanking and resets to 0 at every VSYNC entry.
- Latency:
  - rd_en/rd_addr are asserted in cycle N; rd_data is sampled in N+1; post_img_Bit is valid in N+2.
  - post_frame_vsync, post_frame_href and post_frame_clken are delayed through the same pipeline, so they appear exactly 2 cycles after the internal timing. All three remain mutually aligned with the data.
- busy: 1 from the cycle after accepted start until IDLE is re-entered, plus the 2-cycle pipeline drain.
- Continuous mode: there is no gap cycle between frames; VSYNC line 0 follows the last VFRONT cycle directly.
- Output invariants:
  - post_frame_href is never 1 while post_frame_vsync is 1.
  - post_frame_clken == post_frame_href at all times.

Test Plan:
- Reset with params IMG_W=4, IMG_H=2, H_BLANK=2, VSYNC_LINES=1, V_BACK=1, V_FRONT=1 (line=6 cycles, frame=30). Memory model rd_data=addr+0x100000.
  - All outputs are 0 after reset.
  - 20 idle cycles with start=0 produce no rd_en.
- Single frame: start pulse, continuous=0 ->
  - post_frame_vsync is high for 6 cycles.
  - post_frame_href is high in two 4-cycle bursts, 2 cycles apart.
  - post_img_Bit = 0x100000..0x100007 in order.
  - Exactly one frame_done pulse; busy drops; FSM is in IDLE.
- Latency check: first rd_en (addr 0) at cycle N -> post_frame_href=1 with post_img_Bit=0x100000 at cycle N+2. clken equals href in every cycle.
- Continuous: start with continuous=1 for 3 frames, then drop it ->
  - 3 frame_done pulses, 30 cycles apart.
  - rd_addr restarts at 0 each frame.
  - No gap cycle between frames.
  - Generation stops after the frame in which continuous=0 was sampled.
- Start while busy: extra start pulses mid-frame are ignored; frame length stays exactly 30 cycles.
- Reset mid-frame: assert rst_n=0 during the second active line ->
  - Outputs go to 0 immediately.
  - After release, a new start produces a full frame beginning at addr 0.
